// File: rtl/vend_pkg.sv
// Types shared between the coin acceptor and the downstream vend FSM.
package vend_pkg;

    // Coin code presented to vend; 2'b11 is never driven.
    typedef enum logic [1:0] {
        COIN_NONE   = 2'b00,
        COIN_NICKEL = 2'b01,
        COIN_DIME   = 2'b10
    } coin_t;

    // Output sequencer states of the coin acceptor.
    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        GAP
    } acc_state_t;

endpackage

// File: rtl/coin_debounce.sv
// One slot sensor: 2-flop synchroniser, debounce filter, rising-edge event
// pulse and a high-time counter that flags a jammed slot.
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_PULSE       = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic sense,
    output logic rise,
    output logic long_high
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(MAX_PULSE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HIGH_MAX = HW'(MAX_PULSE);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] stable_cnt;
    logic [HW-1:0] high_cnt;

    // Bring the asynchronous sensor into the clock domain.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours; blocking here would collapse the
    // two synchroniser stages into one.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= sense;
            sync2 <= sync1;
        end
    end

    // Toggle the debounced level after DEBOUNCE_CYCLES consecutive differing
    // samples; a rising toggle emits a one-cycle event.
    always_ff @(posedge clock) begin
        if (reset) begin
            level      <= 1'b0;
            stable_cnt <= '0;
            rise       <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sync2 != level) begin
                if (stable_cnt == CNT_LAST) begin
                    level      <= sync2;
                    stable_cnt <= '0;
                    rise       <= sync2;
                end else begin
                    stable_cnt <= stable_cnt + CW'(1);
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

    // Count cycles the debounced level has been high, saturating at MAX_PULSE.
    always_ff @(posedge clock) begin
        if (reset) begin
            high_cnt <= '0;
        end else if (!level) begin
            high_cnt <= '0;
        end else if (high_cnt != HIGH_MAX) begin
            high_cnt <= high_cnt + HW'(1);
        end
    end

    // High for longer than MAX_PULSE cycles: the slot is stuck.
    assign long_high = level && (high_cnt == HIGH_MAX);

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: debounces both slot sensors, queues accepted
// coins and presents each one to vend as a single-cycle code with an idle gap.
module coin_acceptor
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_PULSE       = 16,
    parameter int GAP_CYCLES      = 2,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          nickel_sense,
    input  logic                          dime_sense,
    output logic [1:0]                    coin,
    output logic                          reject,
    output logic                          jam,
    output logic [$clog2(FIFO_DEPTH):0]   pending
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

    logic nickel_rise;
    logic dime_rise;
    logic nickel_long;
    logic dime_long;

    coin_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .MAX_PULSE       (MAX_PULSE)
    ) u_nickel (
        .clock     (clock),
        .reset     (reset),
        .sense     (nickel_sense),
        .rise      (nickel_rise),
        .long_high (nickel_long)
    );

    coin_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .MAX_PULSE       (MAX_PULSE)
    ) u_dime (
        .clock     (clock),
        .reset     (reset),
        .sense     (dime_sense),
        .rise      (dime_rise),
        .long_high (dime_long)
    );

    coin_t         fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    acc_state_t    state;
    coin_t         coin_q;
    logic [GW-1:0] gap_cnt;

    logic          push;
    logic          pop;
    logic          reject_next;
    coin_t         push_code;

    // Pop whenever the sequencer is idle and something is queued.
    assign pop = (state == IDLE) && (count != '0);

    // Accept, reject or ignore this cycle's sensor events. Fullness uses the
    // registered count, so a same-cycle pop does not make room.
    // NOTE: every output gets a default first so no path leaves a value held,
    // which would otherwise infer a latch.
    always_comb begin
        push        = 1'b0;
        push_code   = COIN_NONE;
        reject_next = 1'b0;
        if (!jam && (nickel_rise || dime_rise)) begin
            if ((nickel_rise && dime_rise) || (count == FULL_COUNT)) begin
                reject_next = 1'b1;
            end else begin
                push      = 1'b1;
                push_code = nickel_rise ? COIN_NICKEL : COIN_DIME;
            end
        end
    end

    // Queue storage write port.
    // NOTE: the storage array is not reset; emptiness is defined by the
    // pointers and count alone, so clearing those discards any queued coins.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_code;
        end
    end

    // Queue pointers and occupancy; pointers wrap modulo FIFO_DEPTH.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Output sequencer: one cycle of coin code, then GAP_CYCLES of idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            coin_q  <= COIN_NONE;
            gap_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        coin_q <= fifo_mem[rd_ptr];
                        state  <= DRIVE;
                    end else begin
                        coin_q <= COIN_NONE;
                    end
                end
                DRIVE: begin
                    coin_q  <= COIN_NONE;
                    gap_cnt <= '0;
                    state   <= GAP;
                end
                GAP: begin
                    coin_q <= COIN_NONE;
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    coin_q <= COIN_NONE;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Registered reject pulse and sticky jam flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            reject <= 1'b0;
            jam    <= 1'b0;
        end else begin
            reject <= reject_next;
            jam    <= jam | nickel_long | dime_long;
        end
    end

    assign coin    = coin_q;
    assign pending = count;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: per-cycle vector table for the main
// behaviours plus hand-written sequences for reset and queue-full corners.
module tb_coin_acceptor;
    import vend_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       nickel_sense;
    logic       dime_sense;
    logic [1:0] coin;
    logic       reject;
    logic       jam;
    logic [2:0] pending;

    // Second instance with a long gap so arrivals outpace draining.
    logic       s_nickel;
    logic       s_dime;
    logic [1:0] s_coin;
    logic       s_reject;
    logic       s_jam;
    logic [2:0] s_pending;

    coin_acceptor dut (
        .clock        (clock),
        .reset        (reset),
        .nickel_sense (nickel_sense),
        .dime_sense   (dime_sense),
        .coin         (coin),
        .reject       (reject),
        .jam          (jam),
        .pending      (pending)
    );

    coin_acceptor #(.GAP_CYCLES(60)) dut_slow (
        .clock        (clock),
        .reset        (reset),
        .nickel_sense (s_nickel),
        .dime_sense   (s_dime),
        .coin         (s_coin),
        .reject       (s_reject),
        .jam          (s_jam),
        .pending      (s_pending)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       nickel;
        logic       dime;
        logic [1:0] coin;
        logic       reject;
        logic       jam;
        logic [2:0] pending;
    } vec_t;

    vec_t vecs [128];
    int   nvec   = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic add_vec(input logic n, input logic d, input logic [1:0] c,
                           input logic r, input logic j, input logic [2:0] p);
        vecs[nvec] = '{nickel: n, dime: d, coin: c, reject: r, jam: j, pending: p};
        nvec++;
    endtask

    initial begin
        int coins_seen;
        logic [1:0] exp_coin;
        logic       exp_rej;

        // Row i: inputs applied before edge i of the segment, outputs after it.
        // Single nickel held 8 cycles: code 01 at edge 8, queued only after edge 7.
        for (int i = 1; i <= 16; i++)
            add_vec(i <= 8, 1'b0, (i == 8) ? 2'b01 : 2'b00, 1'b0, 1'b0, (i == 7) ? 3'd1 : 3'd0);
        // 3-cycle glitch: never reaches the debounced level.
        for (int i = 1; i <= 12; i++)
            add_vec(i <= 3, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0);
        // Nickel then dime one cycle later: codes back to back, 4 cycles apart.
        for (int i = 1; i <= 16; i++)
            add_vec(i <= 4, (i >= 2) && (i <= 5),
                    (i == 8) ? 2'b01 : ((i == 12) ? 2'b10 : 2'b00),
                    1'b0, 1'b0, ((i >= 7) && (i <= 11)) ? 3'd1 : 3'd0);
        // Collision: both debounced edges together -> reject, nothing queued.
        for (int i = 1; i <= 12; i++)
            add_vec(i <= 4, i <= 4, 2'b00, i == 7, 1'b0, 3'd0);
        // Dime held 30 cycles: one coin, jam after 17 high cycles, later nickel ignored.
        for (int i = 1; i <= 60; i++)
            add_vec((i >= 40) && (i <= 43), i <= 30, (i == 8) ? 2'b10 : 2'b00,
                    1'b0, i >= 23, (i == 7) ? 3'd1 : 3'd0);

        reset        = 1'b1;
        nickel_sense = 1'b0;
        dime_sense   = 1'b0;
        s_nickel     = 1'b0;
        s_dime       = 1'b0;
        repeat (3) tick();
        check("reset coin", coin, 2'b00);
        check("reset reject", reject, 1'b0);
        check("reset jam", jam, 1'b0);
        check("reset pending", pending, 3'd0);
        check("reset slow pending", s_pending, 3'd0);
        reset = 1'b0;

        // Mid-stream reset: two coins accepted, first on the output, then reset.
        for (int i = 1; i <= 8; i++) begin
            nickel_sense = (i <= 4);
            dime_sense   = (i >= 2) && (i <= 5);
            tick();
        end
        check("pre-reset coin", coin, 2'b01);
        check("pre-reset pending", pending, 3'd1);
        nickel_sense = 1'b0;
        dime_sense   = 1'b0;
        reset        = 1'b1;
        tick();
        check("mid reset coin", coin, 2'b00);
        check("mid reset pending", pending, 3'd0);
        check("mid reset jam", jam, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        coins_seen = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (coin != 2'b00) coins_seen++;
        end
        check("discarded coins", coins_seen, 0);
        check("post-reset pending", pending, 3'd0);

        // Vector table.
        for (int i = 0; i < nvec; i++) begin
            nickel_sense = vecs[i].nickel;
            dime_sense   = vecs[i].dime;
            tick();
            check($sformatf("vec%0d coin", i), coin, vecs[i].coin);
            check($sformatf("vec%0d reject", i), reject, vecs[i].reject);
            check($sformatf("vec%0d jam", i), jam, vecs[i].jam);
            check($sformatf("vec%0d pending", i), pending, vecs[i].pending);
        end

        nickel_sense = 1'b0;
        dime_sense   = 1'b0;
        reset        = 1'b1;
        tick();
        check("jam cleared by reset", jam, 1'b0);
        reset = 1'b0;

        // Queue-full corner on the slow instance (drain period 62 cycles).
        // Dime events at edges 6,14,22,30,38,46 and 69; pops at 8,70,132,194,256.
        coins_seen = 0;
        for (int i = 1; i <= 270; i++) begin
            s_dime = (((i - 1) % 8) < 4 && i <= 44) || ((i >= 64) && (i <= 67));
            tick();
            exp_coin = ((i == 8) || (i == 70) || (i == 132) || (i == 194) || (i == 256)) ? 2'b10 : 2'b00;
            exp_rej  = (i == 47) || (i == 70);
            check($sformatf("slow%0d coin", i), s_coin, exp_coin);
            check($sformatf("slow%0d reject", i), s_reject, exp_rej);
            if (s_coin != 2'b00) coins_seen++;
            case (i)
                8:   check("slow pending e8", s_pending, 3'd0);
                15:  check("slow pending e15", s_pending, 3'd1);
                23:  check("slow pending e23", s_pending, 3'd2);
                31:  check("slow pending e31", s_pending, 3'd3);
                39:  check("slow pending full", s_pending, 3'd4);
                47:  check("slow pending after reject", s_pending, 3'd4);
                70:  check("slow pending pop+reject", s_pending, 3'd3);
                256: check("slow pending drained", s_pending, 3'd0);
                default: ;
            endcase
        end
        s_dime = 1'b0;
        check("slow coin total", coins_seen, 5);
        check("slow jam", s_jam, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
